mem_wb_elastic: RTL and testbench

- Parametrised, elastic successor to the plain MEM/WB pipeline register.
- Carries write-back control, load data, ALU result and destination register from the MEM stage to the WB stage.
- Adds valid/ready handshaking, a one-entry skid buffer so MEM_ready is a registered signal, synchronous flush, and suppression of writes to r0.
- Sits between the memory stage and the register-file write-back mux.

---
 rtl/mem_wb_elastic.sv | 139 +++++++++++++
 tb/tb_mem_wb_elastic.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_elastic.sv
// MEM/WB pipeline register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and optional suppression of RegWrite to r0.
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | nothing held, WB_valid=0
// S_ONE   | main register holds the WB entry
// S_FULL  | main and skid both hold entries, MEM_ready=0
module mem_wb_elastic #(
    parameter int CTL_W        = 2,
    parameter int DATA_W       = 32,
    parameter int RD_W         = 5,
    parameter int ZERO_RD_KILL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              MEM_valid,
    output logic              MEM_ready,
    input  logic [CTL_W-1:0]  MEM_ctlwb,
    input  logic [DATA_W-1:0] MEM_rdata,
    input  logic [DATA_W-1:0] MEM_alu_out,
    input  logic [RD_W-1:0]   MEM_rd,
    output logic              WB_valid,
    input  logic              WB_ready,
    output logic [CTL_W-1:0]  WB_ctlwb,
    output logic [DATA_W-1:0] WB_rdata,
    output logic [DATA_W-1:0] WB_alu_out,
    output logic [RD_W-1:0]   WB_rd,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        state, state_nxt;
    logic              main_valid, skid_valid;
    logic [CTL_W-1:0]  main_ctl, skid_ctl, in_ctl;
    logic [DATA_W-1:0] main_rdata, skid_rdata;
    logic [DATA_W-1:0] main_alu, skid_alu;
    logic [RD_W-1:0]   main_rd, skid_rd;
    logic              accept, drain;
    logic              load_main, load_skid, main_from_skid;

    assign accept = MEM_valid & ~skid_valid;
    assign drain  = main_valid & WB_ready;

    always_comb begin
        in_ctl = MEM_ctlwb;
        if ((ZERO_RD_KILL != 0) && (MEM_rd == '0)) in_ctl[0] = 1'b0;
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt = S_ONE;
                    load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && !drain) begin
                    state_nxt = S_FULL;
                    load_skid = 1'b1;
                end else if (!accept && drain) begin
                    state_nxt = S_EMPTY;
                end else if (accept && drain) begin
                    load_main = 1'b1;
                end
            end
            S_FULL: begin
                if (drain) begin
                    state_nxt      = S_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        // Flush discards the incoming entry and overrides any drain.
        if (flush) begin
            state_nxt      = S_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctl   <= '0;
            main_rdata <= '0;
            main_alu   <= '0;
            main_rd    <= '0;
            skid_ctl   <= '0;
            skid_rdata <= '0;
            skid_alu   <= '0;
            skid_rd    <= '0;
        end else begin
            state      <= state_nxt;
            main_valid <= (state_nxt != S_EMPTY);
            skid_valid <= (state_nxt == S_FULL);
            if (load_main) begin
                main_ctl   <= in_ctl;
                main_rdata <= MEM_rdata;
                main_alu   <= MEM_alu_out;
                main_rd    <= MEM_rd;
            end else if (main_from_skid) begin
                main_ctl   <= skid_ctl;
                main_rdata <= skid_rdata;
                main_alu   <= skid_alu;
                main_rd    <= skid_rd;
            end
            if (load_skid) begin
                skid_ctl   <= in_ctl;
                skid_rdata <= MEM_rdata;
                skid_alu   <= MEM_alu_out;
                skid_rd    <= MEM_rd;
            end
        end
    end

    // Ready depends only on the skid flop, never on WB_ready.
    assign MEM_ready  = ~skid_valid;
    assign WB_valid   = main_valid;
    assign WB_ctlwb   = main_valid ? main_ctl : '0;
    assign WB_rdata   = main_rdata;
    assign WB_alu_out = main_alu;
    assign WB_rd      = main_rd;
    assign occupancy  = state;

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Self-checking bench for mem_wb_elastic: scoreboard monitor plus per-scenario tasks.
module tb_mem_wb_elastic;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        MEM_valid;
    logic        MEM_ready;
    logic [1:0]  MEM_ctlwb;
    logic [31:0] MEM_rdata;
    logic [31:0] MEM_alu_out;
    logic [4:0]  MEM_rd;
    logic        WB_valid;
    logic        WB_ready;
    logic [1:0]  WB_ctlwb;
    logic [31:0] WB_rdata;
    logic [31:0] WB_alu_out;
    logic [4:0]  WB_rd;
    logic [1:0]  occupancy;

    logic        nk_MEM_ready;
    logic        nk_WB_valid;
    logic [1:0]  nk_WB_ctlwb;
    logic [31:0] nk_WB_rdata;
    logic [31:0] nk_WB_alu_out;
    logic [4:0]  nk_WB_rd;
    logic [1:0]  nk_occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [70:0] sb_q[$];
    logic [70:0] sb_ent;
    logic [1:0]  sb_ctl;
    logic        sb_ready;

    always #5 clk = ~clk;

    mem_wb_elastic #(.CTL_W(2), .DATA_W(32), .RD_W(5), .ZERO_RD_KILL(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .MEM_valid(MEM_valid), .MEM_ready(MEM_ready), .MEM_ctlwb(MEM_ctlwb),
        .MEM_rdata(MEM_rdata), .MEM_alu_out(MEM_alu_out), .MEM_rd(MEM_rd),
        .WB_valid(WB_valid), .WB_ready(WB_ready), .WB_ctlwb(WB_ctlwb),
        .WB_rdata(WB_rdata), .WB_alu_out(WB_alu_out), .WB_rd(WB_rd),
        .occupancy(occupancy)
    );

    mem_wb_elastic #(.CTL_W(2), .DATA_W(32), .RD_W(5), .ZERO_RD_KILL(0)) dut_nk (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .MEM_valid(MEM_valid), .MEM_ready(nk_MEM_ready), .MEM_ctlwb(MEM_ctlwb),
        .MEM_rdata(MEM_rdata), .MEM_alu_out(MEM_alu_out), .MEM_rd(MEM_rd),
        .WB_valid(nk_WB_valid), .WB_ready(WB_ready), .WB_ctlwb(nk_WB_ctlwb),
        .WB_rdata(nk_WB_rdata), .WB_alu_out(nk_WB_alu_out), .WB_rd(nk_WB_rd),
        .occupancy(nk_occupancy)
    );

    // Scoreboard: inputs are stable from posedge+1, so the falling edge sees
    // exactly what the next rising edge will capture.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            sb_ready = (sb_q.size() < 2);
            n_checks++;
            if (occupancy !== 2'(sb_q.size())) begin
                n_fail++;
                $display("FAIL sb_occupancy: got %0d expected %0d", occupancy, sb_q.size());
            end
            n_checks++;
            if (MEM_ready !== sb_ready) begin
                n_fail++;
                $display("FAIL sb_mem_ready: got %b expected %b", MEM_ready, sb_ready);
            end
            n_checks++;
            if (WB_valid !== (sb_q.size() != 0)) begin
                n_fail++;
                $display("FAIL sb_wb_valid: got %b expected %b", WB_valid, sb_q.size() != 0);
            end
            n_checks++;
            if (sb_q.size() == 0) begin
                if (WB_ctlwb !== 2'b00) begin
                    n_fail++;
                    $display("FAIL sb_idle_ctl: got %h expected 0", WB_ctlwb);
                end
            end else if ({WB_ctlwb, WB_rdata, WB_alu_out, WB_rd} !== sb_q[0]) begin
                n_fail++;
                $display("FAIL sb_payload: got %h expected %h",
                         {WB_ctlwb, WB_rdata, WB_alu_out, WB_rd}, sb_q[0]);
            end
            if (flush) begin
                sb_q.delete();
            end else begin
                if (WB_ready && sb_q.size() != 0) sb_ent = sb_q.pop_front();
                if (MEM_valid && sb_ready) begin
                    sb_ctl = MEM_ctlwb;
                    if (MEM_rd == 5'd0) sb_ctl[0] = 1'b0;
                    sb_q.push_back({sb_ctl, MEM_rdata, MEM_alu_out, MEM_rd});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] d,
                         input logic [31:0] a, input logic [4:0] r);
        MEM_valid   = v;
        MEM_ctlwb   = c;
        MEM_rdata   = d;
        MEM_alu_out = a;
        MEM_rd      = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; WB_ready = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        #12;
        n_checks++;
        if ({WB_valid, WB_ctlwb, WB_rdata, WB_alu_out, WB_rd, occupancy} !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {WB_valid, WB_ctlwb, WB_rdata, WB_alu_out, WB_rd, occupancy});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++;
        if (MEM_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", MEM_ready);
        end
        cyc();
    endtask

    task automatic test_pass_through();
        WB_ready = 1'b1;
        drive(1'b1, 2'd1, 32'd2, 32'd3, 5'd4);
        cyc();
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if ({WB_valid, WB_ctlwb, WB_rdata, WB_alu_out, WB_rd} !== {1'b1, 2'd1, 32'd2, 32'd3, 5'd4}) begin
            n_fail++;
            $display("FAIL pass_out: got %b/%0d/%0d/%0d/%0d expected 1/1/2/3/4",
                     WB_valid, WB_ctlwb, WB_rdata, WB_alu_out, WB_rd);
        end
        cyc();
        n_checks++;
        if ({WB_valid, WB_ctlwb} !== 3'b000) begin
            n_fail++;
            $display("FAIL pass_idle: got valid=%b ctl=%0d expected 0/0", WB_valid, WB_ctlwb);
        end
    endtask

    task automatic test_backpressure();
        WB_ready = 1'b0;
        drive(1'b1, 2'd1, 32'hA0, 32'hA1, 5'd5);
        cyc();
        drive(1'b1, 2'd3, 32'hB0, 32'hB1, 5'd6);
        cyc();
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if ({occupancy, MEM_ready, WB_rd} !== {2'd2, 1'b0, 5'd5}) begin
            n_fail++;
            $display("FAIL bp_full: got occ=%0d ready=%b rd=%0d expected 2/0/5",
                     occupancy, MEM_ready, WB_rd);
        end
        cyc();
        WB_ready = 1'b1;
        cyc();
        n_checks++;
        if ({occupancy, MEM_ready, WB_valid, WB_rd} !== {2'd1, 1'b1, 1'b1, 5'd6}) begin
            n_fail++;
            $display("FAIL bp_drain_a: got occ=%0d ready=%b valid=%b rd=%0d expected 1/1/1/6",
                     occupancy, MEM_ready, WB_valid, WB_rd);
        end
        cyc();
        n_checks++;
        if ({occupancy, WB_valid} !== {2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_drain_b: got occ=%0d valid=%b expected 0/0", occupancy, WB_valid);
        end
    endtask

    task automatic test_back_to_back();
        WB_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i), 32'(100 + i), 32'(200 + i), 5'(8 + i));
            cyc();
            n_checks++;
            if ({occupancy, WB_rd, WB_alu_out} !== {2'd1, 5'(8 + i), 32'(200 + i)}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got occ=%0d rd=%0d alu=%0d expected 1/%0d/%0d",
                         i, occupancy, WB_rd, WB_alu_out, 8 + i, 200 + i);
            end
        end
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        cyc();
        n_checks++;
        if (WB_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got valid=%b expected 0", WB_valid);
        end
    endtask

    task automatic test_r0_kill();
        WB_ready = 1'b1;
        drive(1'b1, 2'd3, 32'h55, 32'h66, 5'd0);
        cyc();
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if ({WB_ctlwb, WB_rdata, WB_alu_out} !== {2'd2, 32'h55, 32'h66}) begin
            n_fail++;
            $display("FAIL r0_kill: got ctl=%0d rdata=%h alu=%h expected 2/55/66",
                     WB_ctlwb, WB_rdata, WB_alu_out);
        end
        n_checks++;
        if (nk_WB_ctlwb !== 2'd3) begin
            n_fail++;
            $display("FAIL r0_nokill: got ctl=%0d expected 3", nk_WB_ctlwb);
        end
        cyc();
    endtask

    task automatic test_flush();
        WB_ready = 1'b0;
        drive(1'b1, 2'd1, 32'hC0, 32'hC1, 5'd7);
        cyc();
        drive(1'b1, 2'd1, 32'hD0, 32'hD1, 5'd8);
        cyc();
        flush = 1'b1;
        WB_ready = 1'b1;
        drive(1'b1, 2'd1, 32'hE0, 32'hE1, 5'd9);
        cyc();
        flush = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if ({WB_valid, occupancy, MEM_ready} !== {1'b0, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_state: got valid=%b occ=%0d ready=%b expected 0/0/1",
                     WB_valid, occupancy, MEM_ready);
        end
        cyc();
        n_checks++;
        if (WB_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_discard: got valid=%b rd=%0d expected valid 0", WB_valid, WB_rd);
        end
    endtask

    task automatic test_async_reset();
        WB_ready = 1'b0;
        drive(1'b1, 2'd3, 32'hF0, 32'hF1, 5'd10);
        cyc();
        drive(1'b1, 2'd3, 32'hF2, 32'hF3, 5'd11);
        cyc();
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if (occupancy !== 2'd2) begin
            n_fail++;
            $display("FAIL areset_pre: got occ=%0d expected 2", occupancy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({WB_valid, WB_ctlwb, WB_rdata, WB_alu_out, WB_rd, occupancy, MEM_ready} !== {74'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL areset_now: got %h expected %h",
                     {WB_valid, WB_ctlwb, WB_rdata, WB_alu_out, WB_rd, occupancy, MEM_ready}, {74'd0, 1'b1});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++;
        if ({MEM_ready, occupancy} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL areset_release: got ready=%b occ=%0d expected 1/0", MEM_ready, occupancy);
        end
        WB_ready = 1'b1;
        drive(1'b1, 2'd1, 32'h11, 32'h22, 5'd12);
        cyc();
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if ({WB_valid, WB_rd} !== {1'b1, 5'd12}) begin
            n_fail++;
            $display("FAIL areset_recover: got valid=%b rd=%0d expected 1/12", WB_valid, WB_rd);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_back_to_back();
        test_r0_kill();
        test_flush();
        test_async_reset();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
